// File: rtl/gal_arb_pkg.sv
// Shared types and helpers for the GAL output-enable arbiter.
// The state encoding is fixed at two bits so the state register is always the same width.
package gal_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Width needed to hold an index or count, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/gal_oe_arbiter_if.sv
// Bus between the requesters and the OLMC output-enable arbiter.
// The arbiter sits on the master side; requesters and OLMC drivers sit on the slave side.
interface gal_oe_arbiter_if
    import gal_arb_pkg::*;
#(
    parameter int N = 4
);
    localparam int IW = clog2_min1(N);

    logic [N-1:0]  req;
    logic [N-1:0]  oe;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          turn;

    modport master (
        input  req,
        output oe,
        output gnt_id,
        output busy,
        output turn
    );

    modport slave (
        output req,
        input  oe,
        input  gnt_id,
        input  busy,
        input  turn
    );

endinterface

// File: rtl/gal_oe_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr_i, wrapping modulo N.
// The request vector is duplicated so that the wrap-around search becomes a plain priority encode.
module rr_pick
    import gal_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [2*N-1:0] masked;
    int             first;

    // NOTE: every variable written in this block gets a value before any condition, so no latch is inferred.
    always_comb begin
        masked = {req_i, req_i};
        first  = 0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(ptr_i)) begin
                masked[i] = 1'b0;
            end
        end
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) begin
                first = i;
            end
        end
        valid_o = |req_i;
        idx_o   = (first >= N) ? IW'(first - N) : IW'(first);
    end

endmodule

// File: rtl/gal_oe_arbiter.sv
// Round-robin arbiter that drives one-hot registered output enables for OLMC tri-state drivers
// on a shared GAL pin, inserting all-disabled turnaround cycles between grants.
module gal_oe_arbiter
    import gal_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int HOLD_MAX    = 8,
    parameter int TURN_CYCLES = 1
) (
    input logic              C,
    input logic              R,
    gal_oe_arbiter_if.master bus
);

    localparam int IW = clog2_min1(N);
    localparam int CW = clog2_min1(((HOLD_MAX > TURN_CYCLES) ? HOLD_MAX : TURN_CYCLES) + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
    localparam logic [IW-1:0] PTR_LAST  = IW'(N - 1);

    arb_state_t    state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gnt_id_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  oe_q;
    logic          busy_q;
    logic          turn_q;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_oe;
    logic [IW-1:0] ptr_next;
    logic          hold_go;

    rr_pick #(.N(N)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pick_oe  = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    // The pointer wraps explicitly so non-power-of-two N never points at a missing requester.
    assign ptr_next = (gnt_id_q == PTR_LAST) ? '0 : gnt_id_q + 1'b1;
    assign hold_go  = bus.req[gnt_id_q] && (cnt_q < HOLD_LAST);

    // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge C) begin
        if (R) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            cnt_q    <= '0;
            oe_q     <= '0;
            busy_q   <= 1'b0;
            turn_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    turn_q <= 1'b0;
                    if (pick_valid) begin
                        oe_q     <= pick_oe;
                        gnt_id_q <= pick_idx;
                        busy_q   <= 1'b1;
                        state_q  <= GRANT;
                    end else begin
                        oe_q   <= '0;
                        busy_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (hold_go) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        oe_q    <= '0;
                        busy_q  <= 1'b0;
                        turn_q  <= 1'b1;
                        ptr_q   <= ptr_next;
                        cnt_q   <= '0;
                        state_q <= TURN;
                    end
                end
                TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        // Last gap cycle arbitrates directly so a waiting winner skips IDLE.
                        cnt_q  <= '0;
                        turn_q <= 1'b0;
                        if (pick_valid) begin
                            oe_q     <= pick_oe;
                            gnt_id_q <= pick_idx;
                            busy_q   <= 1'b1;
                            state_q  <= GRANT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_q    <= '0;
                    busy_q  <= 1'b0;
                    turn_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.oe     = oe_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = busy_q;
    assign bus.turn   = turn_q;

endmodule
